// File: rtl/esfa_pkg.sv
// esfa_pkg: opcode encoding shared by the ESFA lookup array and its tree nodes.
package esfa_pkg;

    typedef logic [1:0] esfa_op_t;

    localparam esfa_op_t OP_LOOKUP = 2'b00;
    localparam esfa_op_t OP_WRITE  = 2'b01;
    localparam esfa_op_t OP_CLEAR  = 2'b10;

endpackage

// File: rtl/esfa_reduce_node.sv
// esfa_reduce_node: one registered 2:1 node of the lookup reduction tree.
// The right child always covers higher cell handles than the left child, so
// preferring a right hit returns the most recently written matching cell.
module esfa_reduce_node #(
    parameter int VAL_W = 8,
    parameter int HW    = 3
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             l_hit_i,
    input  logic [VAL_W-1:0] l_value_i,
    input  logic [HW-1:0]    l_handle_i,
    input  logic             r_hit_i,
    input  logic [VAL_W-1:0] r_value_i,
    input  logic [HW-1:0]    r_handle_i,
    output logic             hit_o,
    output logic [VAL_W-1:0] value_o,
    output logic [HW-1:0]    handle_o
);

    logic             hit_q,    hit_d;
    logic [VAL_W-1:0] value_q,  value_d;
    logic [HW-1:0]    handle_q, handle_d;

    // Select the right child on a right hit, otherwise pass the left child.
    always_comb begin
        hit_d    = l_hit_i;
        value_d  = l_value_i;
        handle_d = l_handle_i;
        if (r_hit_i) begin
            hit_d    = r_hit_i;
            value_d  = r_value_i;
            handle_d = r_handle_i;
        end
    end

    // Level register; holds its contents while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (en_i) begin
            hit_q    <= hit_d;
            value_q  <= value_d;
            handle_q <= handle_d;
        end
    end

    assign hit_o    = hit_q;
    assign value_o  = value_q;
    assign handle_o = handle_q;

endmodule

// File: rtl/esfa_lookup_array.sv
// esfa_lookup_array: DEPTH tagged cells {index, value, ctx} with append-only
// allocation. WRITE, CLEAR and LOOKUP share one in-order op stream; every op
// yields exactly one response after a compare stage plus HW tree levels.
module esfa_lookup_array
    import esfa_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int IDX_W = 8,
    parameter  int VAL_W = 8,
    parameter  int CTX_W = 8,
    localparam int HW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [IDX_W-1:0] op_index,
    input  logic [VAL_W-1:0] op_value,
    input  logic [CTX_W-1:0] op_ctx,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [VAL_W-1:0] rsp_value,
    output logic [HW-1:0]    rsp_handle,
    output logic [HW:0]      count,
    output logic             full,
    output logic             err_ovf
);

    localparam int NN = 2 * DEPTH - 1;

    logic stall;
    logic en;
    logic accept;
    logic is_lookup;
    logic is_write;
    logic is_clear;
    logic wr_ok;
    logic full_w;

    // Cell storage: valid bits are control, contents are plain data.
    logic [DEPTH-1:0] cell_vld_q, cell_vld_d;
    logic [IDX_W-1:0] cell_idx_q [DEPTH];
    logic [VAL_W-1:0] cell_val_q [DEPTH];
    logic [CTX_W-1:0] cell_ctx_q [DEPTH];
    logic [HW:0]      count_q, count_d;
    logic             err_ovf_q, err_ovf_d;

    // Stage 0: per-cell compare results (leaves of the tree).
    logic [DEPTH-1:0] cmp_hit;
    logic [DEPTH-1:0] leaf_hit_q;
    logic [VAL_W-1:0] leaf_val_q [DEPTH];

    // Side-band pipeline travelling alongside the tree levels 0..HW.
    logic [HW:0]   vld_q, vld_d;
    logic [HW:0]   wr_q;
    logic [HW:0]   whit_q;
    logic [HW-1:0] whdl_q [HW+1];

    // Tree in heap order: node n has children 2n+1 (left) and 2n+2 (right);
    // leaf for cell i sits at DEPTH-1+i, root at 0.
    logic             node_hit [NN];
    logic [VAL_W-1:0] node_val [NN];
    logic [HW-1:0]    node_hdl [NN];

    assign full_w    = (count_q == (HW+1)'(DEPTH));
    assign stall     = vld_q[HW] && !rsp_ready;
    assign en        = !stall;
    assign op_ready  = !stall && !reset;
    assign accept    = op_valid && op_ready;
    assign is_lookup = (op_code == OP_LOOKUP);
    assign is_write  = (op_code == OP_WRITE);
    assign is_clear  = (op_code == OP_CLEAR);
    assign wr_ok     = accept && is_write && !full_w;

    // Allocator, valid bits and overflow flag take effect at the accept edge.
    always_comb begin
        count_d    = count_q;
        err_ovf_d  = err_ovf_q;
        cell_vld_d = cell_vld_q;
        if (accept && is_clear) begin
            count_d    = '0;
            err_ovf_d  = 1'b0;
            cell_vld_d = '0;
        end else if (accept && is_write) begin
            if (full_w) begin
                err_ovf_d = 1'b1;
            end else begin
                cell_vld_d[count_q[HW-1:0]] = 1'b1;
                count_d = count_q + (HW+1)'(1);
            end
        end
    end

    // Pipeline valids advance one level per unstalled cycle.
    always_comb begin
        vld_d = vld_q;
        if (en) begin
            vld_d = {vld_q[HW-1:0], accept};
        end
    end

    // Control state: the only registers cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_vld_q <= '0;
            count_q    <= '0;
            err_ovf_q  <= 1'b0;
            vld_q      <= '0;
        end else begin
            cell_vld_q <= cell_vld_d;
            count_q    <= count_d;
            err_ovf_q  <= err_ovf_d;
            vld_q      <= vld_d;
        end
    end

    // Cell contents are written into the next free slot on a non-full WRITE.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            cell_idx_q[count_q[HW-1:0]] <= op_index;
            cell_val_q[count_q[HW-1:0]] <= op_value;
            cell_ctx_q[count_q[HW-1:0]] <= op_ctx;
        end
    end

    // Match every cell against the incoming LOOKUP; other ops never hit.
    always_comb begin
        cmp_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cmp_hit[i] = is_lookup && cell_vld_q[i] &&
                         (cell_idx_q[i] == op_index) && (cell_ctx_q[i] == op_ctx);
        end
    end

    // Stage 0 leaves plus the WRITE side-band, shifted level by level.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                leaf_hit_q[i] <= cmp_hit[i];
                leaf_val_q[i] <= cmp_hit[i] ? cell_val_q[i] : '0;
            end
            wr_q[0]   <= is_write;
            whit_q[0] <= !full_w;
            whdl_q[0] <= full_w ? '0 : count_q[HW-1:0];
            for (int k = 1; k <= HW; k++) begin
                wr_q[k]   <= wr_q[k-1];
                whit_q[k] <= whit_q[k-1];
                whdl_q[k] <= whdl_q[k-1];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_leaf
        assign node_hit[DEPTH-1+i] = leaf_hit_q[i];
        assign node_val[DEPTH-1+i] = leaf_val_q[i];
        assign node_hdl[DEPTH-1+i] = HW'(i);
    end

    for (genvar n = 0; n < DEPTH - 1; n++) begin : g_node
        esfa_reduce_node #(
            .VAL_W (VAL_W),
            .HW    (HW)
        ) u_node (
            .clk        (clk),
            .en_i       (en),
            .l_hit_i    (node_hit[2*n+1]),
            .l_value_i  (node_val[2*n+1]),
            .l_handle_i (node_hdl[2*n+1]),
            .r_hit_i    (node_hit[2*n+2]),
            .r_value_i  (node_val[2*n+2]),
            .r_handle_i (node_hdl[2*n+2]),
            .hit_o      (node_hit[n]),
            .value_o    (node_val[n]),
            .handle_o   (node_hdl[n])
        );
    end

    assign rsp_valid  = vld_q[HW];
    assign rsp_hit    = vld_q[HW] && (wr_q[HW] ? whit_q[HW] : node_hit[0]);
    assign rsp_value  = (vld_q[HW] && !wr_q[HW]) ? node_val[0] : '0;
    assign rsp_handle = !vld_q[HW] ? '0 : (wr_q[HW] ? whdl_q[HW] : node_hdl[0]);

    assign count   = count_q;
    assign full    = full_w;
    assign err_ovf = err_ovf_q;

endmodule
